// File: rtl/core_run_ctrl.sv
// rtl/core_run_ctrl.sv - boot loader and run sequencer for the single-cycle RISC-V core
// Optional self-loop halt detection: define RUN_CTRL_LOOP_HALT_EN.
module core_run_ctrl #(
  parameter int          IMEM_AW    = 5,
  parameter int          CYC_W      = 32,
  parameter logic [31:0] HALT_INSTR = 32'h00100073
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [IMEM_AW:0]   load_len,
  input  logic [CYC_W-1:0]   max_cycles,
  input  logic               ld_valid,
  input  logic [7:0]         ld_data,
  output logic               ld_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [31:0]        imem_wdata,
  input  logic [31:0]        instr,
  input  logic [31:0]        pc,
  output logic               core_rst,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic               len_err,
  output logic [CYC_W-1:0]   cycle_count
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

  localparam logic [IMEM_AW:0] DEPTH   = {1'b1, {IMEM_AW{1'b0}}};
  localparam logic [IMEM_AW:0] WC_ONE  = 1;
  localparam logic [CYC_W-1:0] CYC_ONE = 1;

  state_e               state_q, state_d;
  logic                 ld_ready_q, ld_ready_d;
  logic                 imem_we_q, imem_we_d;
  logic [IMEM_AW-1:0]   imem_waddr_q, imem_waddr_d;
  logic [31:0]          imem_wdata_q, imem_wdata_d;
  logic                 core_rst_q, core_rst_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic                 len_err_q, len_err_d;
  logic [CYC_W-1:0]     cycle_count_q, cycle_count_d;
  logic [IMEM_AW:0]     word_cnt_q, word_cnt_d;
  logic [IMEM_AW:0]     len_q, len_d;
  logic [CYC_W-1:0]     max_q, max_d;
  logic [1:0]           byte_idx_q, byte_idx_d;
  logic [31:0]          word_buf_q, word_buf_d;
  logic                 last_word;
  logic [CYC_W-1:0]     cyc_inc;
  logic [IMEM_AW:0]     word_cnt_inc;

`ifdef RUN_CTRL_LOOP_HALT_EN
  logic [31:0]          pc_prev_q, pc_prev_d;
  logic                 pc_valid_q, pc_valid_d;
`else
  logic                 unused_pc;
  assign unused_pc = ^pc;
`endif

  assign cyc_inc      = cycle_count_q + CYC_ONE;
  assign word_cnt_inc = word_cnt_q + WC_ONE;

  always_comb begin
    state_d       = state_q;
    imem_we_d     = 1'b0;
    imem_waddr_d  = imem_waddr_q;
    imem_wdata_d  = imem_wdata_q;
    timeout_d     = timeout_q;
    len_err_d     = len_err_q;
    cycle_count_d = cycle_count_q;
    word_cnt_d    = word_cnt_q;
    len_d         = len_q;
    max_d         = max_q;
    byte_idx_d    = byte_idx_q;
    word_buf_d    = word_buf_q;
    last_word     = 1'b0;
`ifdef RUN_CTRL_LOOP_HALT_EN
    pc_prev_d     = pc;
    pc_valid_d    = (state_q == S_RUN);
`endif

    if (abort) begin
      state_d    = S_IDLE;
      byte_idx_d = 2'd0;
      word_buf_d = 32'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (load_len > DEPTH) begin
              len_err_d = 1'b1;
            end else begin
              len_err_d     = 1'b0;
              timeout_d     = 1'b0;
              cycle_count_d = '0;
              word_cnt_d    = '0;
              byte_idx_d    = 2'd0;
              word_buf_d    = 32'd0;
              len_d         = load_len;
              max_d         = max_cycles;
              state_d       = (load_len == '0) ? S_RUN : S_LOAD;
            end
          end
        end
        S_LOAD: begin
          // word_cnt reaching len means the final write is on the port right now
          if (word_cnt_q == len_q) begin
            state_d = S_RUN;
          end else if (ld_valid && ld_ready_q) begin
            word_buf_d[{byte_idx_q, 3'b000} +: 8] = ld_data;
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              imem_we_d    = 1'b1;
              imem_waddr_d = word_cnt_q[IMEM_AW-1:0];
              imem_wdata_d = {ld_data, word_buf_q[23:0]};
              word_cnt_d   = word_cnt_inc;
              word_buf_d   = 32'd0;
              last_word    = (word_cnt_inc == len_q);
            end
          end
        end
        S_RUN: begin
          cycle_count_d = (cycle_count_q == '1) ? cycle_count_q : cyc_inc;
          if (instr == HALT_INSTR) begin
            state_d   = S_DONE;
            timeout_d = 1'b0;
`ifdef RUN_CTRL_LOOP_HALT_EN
          end else if (pc_valid_q && (pc == pc_prev_q)) begin
            state_d   = S_DONE;
            timeout_d = 1'b0;
`endif
          end else if ((max_q != '0) && (cyc_inc == max_q)) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    ld_ready_d = (state_d == S_LOAD) && !last_word;
    busy_d     = (state_d == S_LOAD) || (state_d == S_RUN);
    done_d     = (state_d == S_DONE);
    core_rst_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ld_ready_q    <= 1'b0;
      imem_we_q     <= 1'b0;
      imem_waddr_q  <= '0;
      imem_wdata_q  <= 32'd0;
      core_rst_q    <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      len_err_q     <= 1'b0;
      cycle_count_q <= '0;
      word_cnt_q    <= '0;
      len_q         <= '0;
      max_q         <= '0;
      byte_idx_q    <= 2'd0;
      word_buf_q    <= 32'd0;
`ifdef RUN_CTRL_LOOP_HALT_EN
      pc_prev_q     <= 32'd0;
      pc_valid_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ld_ready_q    <= ld_ready_d;
      imem_we_q     <= imem_we_d;
      imem_waddr_q  <= imem_waddr_d;
      imem_wdata_q  <= imem_wdata_d;
      core_rst_q    <= core_rst_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      len_err_q     <= len_err_d;
      cycle_count_q <= cycle_count_d;
      word_cnt_q    <= word_cnt_d;
      len_q         <= len_d;
      max_q         <= max_d;
      byte_idx_q    <= byte_idx_d;
      word_buf_q    <= word_buf_d;
`ifdef RUN_CTRL_LOOP_HALT_EN
      pc_prev_q     <= pc_prev_d;
      pc_valid_q    <= pc_valid_d;
`endif
    end
  end

  assign ld_ready    = ld_ready_q;
  assign imem_we     = imem_we_q;
  assign imem_waddr  = imem_waddr_q;
  assign imem_wdata  = imem_wdata_q;
  assign core_rst    = core_rst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign len_err     = len_err_q;
  assign cycle_count = cycle_count_q;

endmodule
